// File: rtl/hazard_unit_mc_if.sv
// Hazard-unit bundle: datapath register/control taps in,
// stage enables, clears and forwarding selects out.
interface hazard_unit_mc_if #(
    parameter int REG_AW = 5,
    parameter int PERF_W = 32
);
    logic [REG_AW-1:0] Rs1D, Rs2D;
    logic [REG_AW-1:0] Rs1E, Rs2E, RdE;
    logic [REG_AW-1:0] RdM, RdW;
    logic              LoadE, MulDivE, PCSrcE;
    logic              RegWriteM, MemReqM, MemReadyM;
    logic              RegWriteW;
    logic              StallF, StallD, StallE, StallM;
    logic              FlushD, FlushE, FlushM, FlushW;
    logic [1:0]        ForwardAE, ForwardBE;
    logic              MulDivBusy;
    logic [PERF_W-1:0] StallCount;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output LoadE, MulDivE, PCSrcE,
        output RegWriteM, MemReqM, MemReadyM, RegWriteW,
        input  StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushM, FlushW,
        input  ForwardAE, ForwardBE, MulDivBusy, StallCount
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  LoadE, MulDivE, PCSrcE,
        input  RegWriteM, MemReqM, MemReadyM, RegWriteW,
        output StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushM, FlushW,
        output ForwardAE, ForwardBE, MulDivBusy, StallCount
    );
endinterface

// File: rtl/hazard_unit_mc.sv
// Hazard/forwarding control with multi-cycle mul/div hold,
// data-memory freeze and a saturating stall-cycle counter.
module hazard_unit_mc #(
    parameter int REG_AW     = 5,
    parameter int MULDIV_LAT = 4,
    parameter int PERF_W     = 32
) (
    input logic             clk,
    input logic             reset,
    hazard_unit_mc_if.slave hz
);
    localparam int CNT_W     = $clog2(MULDIV_LAT) + 1;
    localparam int CNT_START = (MULDIV_LAT > 1) ? MULDIV_LAT - 2 : 0;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CNT_START);
    localparam logic MD_EN = (MULDIV_LAT > 1);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] MD   = 2'b01;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [PERF_W-1:0] stallCount;
    logic              inMd;
    logic              memStall, lwStall, mdStall;
    logic              stallF;

    function automatic logic [1:0] fwdSel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rdM,
        input logic              wrM,
        input logic [REG_AW-1:0] rdW,
        input logic              wrW
    );
        if (rs != '0 && rs == rdM && wrM)
            return 2'b10;
        else if (rs != '0 && rs == rdW && wrW)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Any encoding other than MD behaves as IDLE.
    assign inMd     = (state == MD);
    assign memStall = hz.MemReqM & ~hz.MemReadyM;
    assign lwStall  = hz.LoadE & (hz.RdE != '0) &
                      ((hz.Rs1D == hz.RdE) | (hz.Rs2D == hz.RdE));
    assign mdStall  = (~inMd & hz.MulDivE & MD_EN) |
                      (inMd & (cnt != '0));

    always_comb begin
        stallF       = 1'b0;
        hz.StallD    = 1'b0;
        hz.StallE    = 1'b0;
        hz.StallM    = 1'b0;
        hz.FlushD    = 1'b0;
        hz.FlushE    = 1'b0;
        hz.FlushM    = 1'b0;
        hz.FlushW    = 1'b0;
        hz.ForwardAE = fwdSel(hz.Rs1E, hz.RdM, hz.RegWriteM,
                              hz.RdW, hz.RegWriteW);
        hz.ForwardBE = fwdSel(hz.Rs2E, hz.RdM, hz.RegWriteM,
                              hz.RdW, hz.RegWriteW);
        hz.MulDivBusy = inMd;
        if (reset) begin
            hz.FlushD     = 1'b1;
            hz.FlushE     = 1'b1;
            hz.FlushM     = 1'b1;
            hz.FlushW     = 1'b1;
            hz.ForwardAE  = 2'b00;
            hz.ForwardBE  = 2'b00;
            hz.MulDivBusy = 1'b0;
        end else if (memStall) begin
            stallF    = 1'b1;
            hz.StallD = 1'b1;
            hz.StallE = 1'b1;
            hz.StallM = 1'b1;
            hz.FlushW = 1'b1;
        end else if (mdStall) begin
            stallF    = 1'b1;
            hz.StallD = 1'b1;
            hz.StallE = 1'b1;
            hz.FlushM = 1'b1;
        end else begin
            stallF    = lwStall;
            hz.StallD = lwStall;
            hz.FlushD = hz.PCSrcE;
            hz.FlushE = lwStall | hz.PCSrcE;
        end
    end

    assign hz.StallF     = stallF;
    assign hz.StallCount = stallCount;

    // The whole sequence freezes while memory holds M.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (!memStall) begin
            if (inMd) begin
                if (cnt != '0)
                    cnt <= cnt - 1'b1;
                else
                    state <= IDLE;
            end else if (hz.MulDivE && MD_EN) begin
                state <= MD;
                cnt   <= CNT_INIT;
            end else begin
                state <= IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            stallCount <= '0;
        else if (stallF && stallCount != '1)
            stallCount <= stallCount + 1'b1;
    end
endmodule
